// File: rtl/rv32_regfile.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports, one write port, x0 reads zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module rv32_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32  // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_valid;

  assign wr_valid = we && (rd_addr != '0);

  // Entry 0 is never written, so it holds its reset value of zero forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[rd_addr] <= w_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = regs[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = regs[rs2_addr];
    end
`ifdef REGFILE_BYPASS_EN
    // Write-first: the in-flight write overrides storage; wr_valid already excludes x0.
    if (!reset && wr_valid && (rs1_addr == rd_addr)) begin
      rs1_data = w_data;
    end
    if (!reset && wr_valid && (rs2_addr == rd_addr)) begin
      rs2_data = w_data;
    end
`endif
  end

endmodule

// File: tb/tb_rv32_regfile.sv
// Bench for rv32_regfile: directed vector table, hand-written reset/forwarding sequences, random run vs array model.
module tb_rv32_regfile;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] w_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model [32];

  rv32_regfile dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr),
    .w_data   (w_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: present inputs after the falling edge
  task automatic drive(input logic w, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    we = w; rd_addr = rd; w_data = d; rs1_addr = a1; rs2_addr = a2;
  endtask

  // reference read: stored value, x0 zero, optional write-first forwarding
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 0) ? 32'h0 : model[a];
`ifdef REGFILE_BYPASS_EN
    if (!reset && we && rd_addr != 0 && a == rd_addr && a != 0) v = w_data;
`endif
    return v;
  endfunction

  typedef struct packed {
    logic        w;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] pre;
    reset = 1'b1; we = 1'b0; rd_addr = '0; w_data = '0; rs1_addr = '0; rs2_addr = '0;

    vecs[0] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd1,  32'hDEADBEEF, 5'd1,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd1,  32'h12345678, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd4,  32'hCAFEF00D, 5'd3,  5'd4,  32'h12345678, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 5'd3,  32'h0,        5'd3,  5'd3,  32'h12345678, 32'h12345678};
    vecs[6] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd4,  32'hA5A5A5A5, 32'hCAFEF00D};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_rs1", rs1_data, 32'h0);
    check("reset_rs2", rs2_data, 32'h0);

    // directed table: write on one edge, read back with we low
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].w, vecs[i].rd, vecs[i].d, vecs[i].a1, vecs[i].a2);
      @(posedge clk);
      #1 we = 1'b0;
      #1;
      check($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
      check($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
    end

    // asynchronous reset between edges clears immediately
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    #1 reset = 1'b1;
    #1;
    check("async_reset_x3", rs1_data, 32'h0);
    check("async_reset_x4", rs2_data, 32'h0);
    // a write on an edge while reset is high is lost
    we = 1'b1; rd_addr = 5'd5; w_data = 32'h55555555;
    @(posedge clk);
    #1 we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rs1_addr = 5'd5;
    #1;
    check("write_in_reset_lost", rs1_data, 32'h0);

    // same-cycle read/write of one register
    drive(1'b1, 5'd7, 32'h11111111, 5'd7, 5'd0);
    @(posedge clk);
    drive(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    pre = 32'h22222222;
`else
    pre = 32'h11111111;
`endif
    check("rw_same_pre_edge", rs1_data, pre);
    @(posedge clk);
    #1;
    check("rw_same_post_edge", rs1_data, 32'h22222222);
    // x0 never forwards
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    check("x0_no_forward", rs1_data, 32'h0);
    @(posedge clk);
    #1 we = 1'b0;

    // random run against an array model; start from a clean reset
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (n % 8 == 0) rs2_addr = rs1_addr;
      if ($urandom_range(0, 24) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end
      #1;
      exp_q.push_back(ref_read(rs1_addr));
      exp_q.push_back(ref_read(rs2_addr));
      check($sformatf("rand%0d_rs1", n), rs1_data, exp_q.pop_front());
      check($sformatf("rand%0d_rs2", n), rs2_data, exp_q.pop_front());
      @(posedge clk);
      if (we && rd_addr != 0) model[rd_addr] = w_data;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_regfile.md
Name: rv32_regfile

Overview:
- Integer register file for the RV32I core: 32 general-purpose registers, each 32 bits wide.
- Two asynchronous (combinational) read ports (rs1, rs2) and one synchronous write port (rd).
- Register x0 is hardwired to zero.
- Sits between decode (operand read) and writeback (result write).

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears every register to 0.
- we  input  1  write enable for the rd port.
- rs1_addr  input  ADDR_W  read port 1 register index.
- rs2_addr  input  ADDR_W  read port 2 register index.
- rd_addr  input  ADDR_W  write port register index.
- w_data  input  DATA_W  write data.
- rs1_data  output  DATA_W  contents of register rs1_addr.
- rs2_data  output  DATA_W  contents of register rs2_addr.

Behaviour:
- Storage: NUM_REGS entries of DATA_W bits.
- Reset:
  - While reset=1, all entries are forced to 0 immediately (asynchronously), independent of clk.
  - Both read outputs then read 0.
  - Writes are ignored while reset is asserted.
- Write:
  - On a rising clk edge with reset=0, we=1 and rd_addr!=0, entry[rd_addr] <= w_data.
  - Write latency is 1 cycle: the new value is visible on the read ports after that edge.
- x0:
  - A write with rd_addr=0 is discarded; no storage is updated.
  - Reading address 0 on either port always returns 0, regardless of write history.
- Read:
  - Purely combinational: rsN_data = (rsN_addr==0) ? 0 : entry[rsN_addr].
  - No clock latency; output settles within the same cycle as an address change.
- Dual read: both ports are independent and may read the same address simultaneously, each returning the same value.
- Same-cycle read/write to the same address (default build): the read returns the old value until the clock edge, then the new value. No internal forwarding.
- we=0: no storage changes, whatever rd_addr and w_data are.
- Reset mid-operation: reset asserted between edges clears all registers at once. A write on the edge while reset is high is lost.
- No X propagation: every entry is defined after the first reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding on both read ports.
  - If we=1, reset=0, rd_addr!=0 and rsN_addr==rd_addr, rsN_data = w_data combinationally in the same cycle.
  - x0 reads still return 0.
- Undefined: no forwarding; reads return stored contents only, as described in Behaviour.
- Storage update timing is identical in both builds.

Test Plan:
1. Assert reset=1, then release it; read rs1_addr=5, rs2_addr=31 -> both outputs 0x00000000.
2. we=1, rd_addr=1, w_data=0xDEADBEEF, one clk edge, then we=0; set rs1_addr=1 -> rs1_data=0xDEADBEEF.
3. we=1, rd_addr=0, w_data=0xFFFFFFFF, one edge; set rs1_addr=0 and rs2_addr=0 -> both read 0x00000000.
4. Write x3=0x12345678 and x4=0xCAFEF00D; set rs1_addr=3, rs2_addr=4 -> 0x12345678 / 0xCAFEF00D. Then set both ports to address 3 -> both read 0x12345678.
5. we=0, rd_addr=3, w_data=0x0, one edge -> x3 still reads 0x12345678. Then assert reset asynchronously mid-cycle, with no clk edge -> x3 reads 0 immediately.
6. With x7=0x11111111, drive we=1, rd_addr=7, w_data=0x22222222, rs1_addr=7 before the edge:
   - Without REGFILE_BYPASS_EN -> rs1_data=0x11111111 before the edge, 0x22222222 after.
   - With REGFILE_BYPASS_EN -> rs1_data=0x22222222 before the edge.
